cmul_rnd_sat: RTL

CMUL_RND_SAT -- requirements
Module: cmul_rnd_sat

---
 rtl/cmul_rnd_sat.sv | 123 ++++++++++++
 1 files changed

// File: rtl/cmul_rnd_sat.sv
// Rounds and saturates complex-multiplier products down to butterfly width.
// Two-stage valid/ready pipeline: S1 rounds, S2 clamps and counts saturated beats.
module cmul_rnd_sat #(
  parameter int BFLY = 10,
  parameter int TW   = 9,
  localparam int SHIFT = TW - 2,
  localparam int IN_W  = BFLY + TW
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic signed [IN_W-1:0] in_re,
  input  logic signed [IN_W-1:0] in_im,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic signed [BFLY-1:0] out_re,
  output logic signed [BFLY-1:0] out_im,
  output logic                   out_last,
  output logic                   out_sat,
  output logic [15:0]            sat_cnt,
  input  logic                   sat_clr
);

  localparam int R_W = IN_W + 1 - SHIFT;
  localparam logic [IN_W:0] RND = {{(IN_W + 1 - SHIFT){1'b0}}, 1'b1, {(SHIFT - 1){1'b0}}};
  localparam logic signed [R_W-1:0] MAXV = R_W'((2 ** (BFLY - 1)) - 1);
  localparam logic signed [R_W-1:0] MINV = ~MAXV;

  logic                  v1_q, v2_q;
  logic signed [R_W-1:0] s1_re_q, s1_im_q, s1_re_d, s1_im_d;
  logic                  s1_last_q;
  logic signed [BFLY-1:0] out_re_q, out_im_q, out_re_d, out_im_d;
  logic                  out_last_q, out_sat_q, out_sat_d;
  logic [15:0]           sat_cnt_q, sat_cnt_d;
  logic                  en1, en2;
  logic signed [IN_W:0]  re_sum, im_sum;
  logic                  re_clip, im_clip;

  assign en2      = !v2_q || out_ready;
  assign en1      = !v1_q || en2;
  assign in_ready = en1;

  // Add half an LSB, then keep the upper bits: round half toward +infinity.
  assign re_sum  = $signed({in_re[IN_W-1], in_re}) + $signed(RND);
  assign im_sum  = $signed({in_im[IN_W-1], in_im}) + $signed(RND);
  assign s1_re_d = re_sum[IN_W:SHIFT];
  assign s1_im_d = im_sum[IN_W:SHIFT];

  always_comb begin
    re_clip  = 1'b0;
    im_clip  = 1'b0;
    out_re_d = s1_re_q[BFLY-1:0];
    out_im_d = s1_im_q[BFLY-1:0];
    if (s1_re_q > MAXV) begin
      re_clip  = 1'b1;
      out_re_d = MAXV[BFLY-1:0];
    end else if (s1_re_q < MINV) begin
      re_clip  = 1'b1;
      out_re_d = MINV[BFLY-1:0];
    end
    if (s1_im_q > MAXV) begin
      im_clip  = 1'b1;
      out_im_d = MAXV[BFLY-1:0];
    end else if (s1_im_q < MINV) begin
      im_clip  = 1'b1;
      out_im_d = MINV[BFLY-1:0];
    end
    out_sat_d = re_clip || im_clip;
  end

  always_comb begin
    sat_cnt_d = sat_cnt_q;
    if (sat_clr)
      sat_cnt_d = 16'd0;
    else if (v2_q && out_ready && out_sat_q && (sat_cnt_q != 16'hFFFF))
      sat_cnt_d = sat_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q      <= 1'b0;
      s1_re_q   <= '0;
      s1_im_q   <= '0;
      s1_last_q <= 1'b0;
    end else if (en1) begin
      v1_q      <= in_valid;
      s1_re_q   <= s1_re_d;
      s1_im_q   <= s1_im_d;
      s1_last_q <= in_last;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2_q       <= 1'b0;
      out_re_q   <= '0;
      out_im_q   <= '0;
      out_last_q <= 1'b0;
      out_sat_q  <= 1'b0;
    end else if (en2) begin
      v2_q       <= v1_q;
      out_re_q   <= out_re_d;
      out_im_q   <= out_im_d;
      out_last_q <= s1_last_q;
      out_sat_q  <= out_sat_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sat_cnt_q <= 16'd0;
    else        sat_cnt_q <= sat_cnt_d;
  end

  assign out_valid = v2_q;
  assign out_re    = out_re_q;
  assign out_im    = out_im_q;
  assign out_last  = out_last_q;
  assign out_sat   = out_sat_q;
  assign sat_cnt   = sat_cnt_q;

endmodule
